// File: rtl/wb_arbiter_rr_qos_pkg.sv
// wb_arbiter_rr_qos_pkg: state encodings and width helper shared by the arbiter files
package wb_arbiter_rr_qos_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_ERR   = 2'd2
   } arb_state_t;

   // ceil(log2(n)) but never less than one bit, so disabled counters still have a legal width
   function automatic int clog2w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/wb_arbiter_rr_qos_if.sv
// wb_arbiter_rr_qos_if: flattened multi-master Wishbone bus plus the shared slave port
interface wb_arbiter_rr_qos_if #(
   parameter int PORTS        = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
   logic [PORTS*ADDR_WIDTH-1:0]   wbm_adr_i;
   logic [PORTS*DATA_WIDTH-1:0]   wbm_dat_i;
   logic [DATA_WIDTH-1:0]         wbm_dat_o;
   logic [PORTS-1:0]              wbm_we_i;
   logic [PORTS*SELECT_WIDTH-1:0] wbm_sel_i;
   logic [PORTS-1:0]              wbm_stb_i;
   logic [PORTS-1:0]              wbm_cyc_i;
   logic [PORTS-1:0]              wbm_ack_o;
   logic [PORTS-1:0]              wbm_err_o;
   logic [ADDR_WIDTH-1:0]         wbs_adr_o;
   logic [DATA_WIDTH-1:0]         wbs_dat_o;
   logic                          wbs_we_o;
   logic [SELECT_WIDTH-1:0]       wbs_sel_o;
   logic                          wbs_stb_o;
   logic                          wbs_cyc_o;
   logic [DATA_WIDTH-1:0]         wbs_dat_i;
   logic                          wbs_ack_i;
   logic [PORTS-1:0]              grant_o;
   logic                          grant_valid_o;

   modport slave (
      input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i, wbs_dat_i, wbs_ack_i,
      output wbm_dat_o, wbm_ack_o, wbm_err_o, wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o,
             wbs_stb_o, wbs_cyc_o, grant_o, grant_valid_o
   );

   modport master (
      output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i, wbs_dat_i, wbs_ack_i,
      input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o,
             wbs_stb_o, wbs_cyc_o, grant_o, grant_valid_o
   );

endinterface

// File: rtl/wb_arbiter_rr_qos_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester above last (wrapping) wins
module rr_pick
   import wb_arbiter_rr_qos_pkg::*;
#(
   parameter  int PORTS = 4,
   localparam int LW    = clog2w(PORTS)
) (
   input  logic [PORTS-1:0] request,
   input  logic [LW-1:0]    last,
   output logic [PORTS-1:0] pick,
   output logic [LW-1:0]    pick_idx,
   output logic             valid
);
   logic [LW-1:0] p;

   // scan last+1, last+2, ... modulo PORTS and keep the first hit
   always_comb begin
      pick     = '0;
      pick_idx = '0;
      valid    = 1'b0;
      p        = '0;
      for (int k = 1; k <= PORTS; k++) begin
         p = LW'((int'(last) + k) % PORTS);
         if (!valid && request[p]) begin
            valid    = 1'b1;
            pick[p]  = 1'b1;
            pick_idx = p;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter_rr_qos.sv
// wb_arbiter_rr_qos: round-robin Wishbone classic arbiter with per-grant quota and stall watchdog
module wb_arbiter_rr_qos
   import wb_arbiter_rr_qos_pkg::*;
#(
   parameter int PORTS        = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int MAX_XFERS    = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic               clk,
   input  logic               rst,
   wb_arbiter_rr_qos_if.slave bus
);
   localparam int LW = clog2w(PORTS);
   localparam int XW = clog2w(MAX_XFERS + 1);
   localparam int WW = clog2w(TIMEOUT + 1);

   arb_state_t       state, state_n;
   logic [LW-1:0]    last, owner, pick_idx;
   logic [PORTS-1:0] grant, pick;
   logic             pick_valid;
   logic [XW-1:0]    xfer_cnt;
   logic [WW-1:0]    wd_cnt;
   logic             owner_cyc, quota_hit, wd_term, drive, err_fire;

   rr_pick #(.PORTS(PORTS)) u_pick (
      .request (bus.wbm_cyc_i),
      .last    (last),
      .pick    (pick),
      .pick_idx(pick_idx),
      .valid   (pick_valid)
   );

   assign bus.wbm_dat_o     = bus.wbs_dat_i;
   assign bus.grant_o       = grant;
   assign bus.grant_valid_o = state == ARB_GRANT;
   assign bus.wbm_ack_o     = grant & {PORTS{drive & bus.wbs_ack_i}};
   assign bus.wbm_err_o     = grant & {PORTS{err_fire}};

   // owner conditions: preemption once the quota is spent under contention, watchdog expiry
   always_comb begin
      owner_cyc = |(bus.wbm_cyc_i & grant);
      quota_hit = MAX_XFERS != 0 && xfer_cnt == XW'(MAX_XFERS) && |(bus.wbm_cyc_i & ~grant);
      wd_term   = TIMEOUT != 0 && wd_cnt == WW'(TIMEOUT);
      drive     = state == ARB_GRANT && owner_cyc && !quota_hit;
      err_fire  = drive && wd_term && !bus.wbs_ack_i;
   end

   // next state and the owner-to-slave request mux, zero whenever the bus is not driven
   always_comb begin
      state_n = state;
      case (state)
         ARB_IDLE:  state_n = pick_valid ? ARB_GRANT : ARB_IDLE;
         ARB_GRANT: state_n = (!owner_cyc || quota_hit) ? ARB_IDLE : err_fire ? ARB_ERR : ARB_GRANT;
         ARB_ERR:   state_n = owner_cyc ? ARB_ERR : ARB_IDLE;
         default:   state_n = ARB_IDLE;
      endcase
      bus.wbs_adr_o = '0;
      bus.wbs_dat_o = '0;
      bus.wbs_we_o  = 1'b0;
      bus.wbs_sel_o = '0;
      bus.wbs_stb_o = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (drive && grant[i]) begin
            bus.wbs_adr_o = bus.wbm_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            bus.wbs_dat_o = bus.wbm_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            bus.wbs_we_o  = bus.wbm_we_i[i];
            bus.wbs_sel_o = bus.wbm_sel_i[i*SELECT_WIDTH +: SELECT_WIDTH];
            bus.wbs_stb_o = bus.wbm_stb_i[i];
         end
      end
      bus.wbs_cyc_o = drive;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ARB_IDLE;
      else state <= state_n;
   end

   // ownership: latch the pick on grant, record the owner as last when the bus is given up
   always_ff @(posedge clk) begin
      if (rst) begin
         last  <= LW'(PORTS - 1);
         owner <= '0;
         grant <= '0;
      end else if (state == ARB_IDLE && pick_valid) begin
         owner <= pick_idx;
         grant <= pick;
      end else if (state != ARB_IDLE && state_n == ARB_IDLE) begin
         last  <= owner;
         grant <= '0;
      end
   end

   // quota and watchdog counters, both cleared outside GRANT so each grant starts fresh
   always_ff @(posedge clk) begin
      if (rst || state != ARB_GRANT) begin
         xfer_cnt <= '0;
         wd_cnt   <= '0;
      end else begin
         if (drive && bus.wbs_ack_i && xfer_cnt != XW'(MAX_XFERS)) xfer_cnt <= xfer_cnt + 1'b1;
         wd_cnt <= bus.wbs_ack_i ? '0 : (bus.wbs_stb_o && wd_cnt != WW'(TIMEOUT)) ? wd_cnt + 1'b1 : wd_cnt;
      end
   end

endmodule
